// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage enables/flushes for load-use, redirect, MDU and memory stalls, halt.
// Optional performance counters are built only when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_en,
  input  logic        id_rs2_en,
  input  logic [4:0]  ex_rd,
  input  logic        ex_load,
  input  logic        ex_redirect,
  input  logic        ex_mdu_start,
  input  logic        mdu_done,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        mdu_busy,
  output logic        halted,
  output logic        mdu_timeout,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam logic [7:0] WD_LIMIT = 8'hFF;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wd_cnt;
  logic [7:0] wd_cnt_nxt;
  logic       timeout_q;
  logic       timeout_set;
  logic       load_use;
  logic [3:0] en;

  assign load_use = ex_load && (ex_rd != 5'd0) &&
                    ((id_rs1_en && (id_rs1 == ex_rd)) ||
                     (id_rs2_en && (id_rs2 == ex_rd)));

  assign {pc_en, ifid_en, idex_en, exmem_en} = en;

  always_comb begin
    state_nxt   = state;
    wd_cnt_nxt  = wd_cnt;
    timeout_set = 1'b0;
    en          = 4'b0000;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    mdu_busy    = 1'b0;
    halted      = 1'b0;

    case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_nxt = MEM_WAIT;
        end else if (ex_mdu_start) begin
          state_nxt  = MDU_WAIT;
          wd_cnt_nxt = 8'd0;
        end else if (halt_req) begin
          state_nxt = HALT;
        end else if (ex_redirect) begin
          en         = 4'b1111;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          // Hold PC and IF/ID, let the load advance, and bubble EX exactly once.
          en         = 4'b0011;
          idex_flush = 1'b1;
        end else begin
          en = 4'b1111;
        end
      end

      MDU_WAIT: begin
        mdu_busy = 1'b1;
        if (mdu_done) begin
          en        = 4'b1111;
          state_nxt = RUN;
        end else if (wd_cnt == WD_LIMIT) begin
          en          = 4'b1111;
          timeout_set = 1'b1;
          state_nxt   = RUN;
        end else begin
          wd_cnt_nxt = wd_cnt + 8'd1;
        end
      end

      MEM_WAIT: begin
        if (mem_ready) begin
          en        = 4'b1111;
          state_nxt = RUN;
        end
      end

      HALT: begin
        halted = 1'b1;
        if (!halt_req) begin
          state_nxt = RUN;
        end
      end

      default: begin
        state_nxt = RUN;
      end
    endcase

    // Reset freezes every stage and flushes the front end, overriding any wait.
    if (!rst_n) begin
      en          = 4'b0000;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      mdu_busy    = 1'b0;
      halted      = 1'b0;
      timeout_set = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      wd_cnt    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      wd_cnt <= wd_cnt_nxt;
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign mdu_timeout = rst_n && (timeout_q || timeout_set);

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= 32'd0;
      flush_q <= 16'd0;
    end else begin
      if (!pc_en) begin
        stall_q <= stall_q + 32'd1;
      end
      if (idex_flush) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multi-cycle sequences, random vs model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_en, id_rs2_en, ex_load, ex_redirect, ex_mdu_start;
  logic        mdu_done, mem_req, mem_ready, halt_req;
  logic        pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush;
  logic        mdu_busy, halted, mdu_timeout;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  logic [5:0]  ctl;

  int checks = 0;
  int fails  = 0;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
    .ex_rd(ex_rd), .ex_load(ex_load), .ex_redirect(ex_redirect), .ex_mdu_start(ex_mdu_start),
    .mdu_done(mdu_done), .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mdu_busy(mdu_busy), .halted(halted), .mdu_timeout(mdu_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush};

  typedef struct {
    string      nm;
    logic [4:0] rs1, rs2, rd;
    logic       rs1_en, rs2_en, ld, redir, start, mreq, mrdy, halt;
    logic [5:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_en = 1'b0; id_rs2_en = 1'b0;
    ex_rd = 5'd0; ex_load = 1'b0; ex_redirect = 1'b0; ex_mdu_start = 1'b0;
    mdu_done = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    rst_n = 1'b0;
    #1;
    chk("rst_ctl", ctl, 6'b000011);
    chk("rst_busy_halted", {mdu_busy, halted}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add_vec(input string nm, input logic [4:0] rs1, input logic rs1_en,
                         input logic [4:0] rs2, input logic rs2_en, input logic [4:0] rd,
                         input logic ld, input logic redir, input logic start,
                         input logic mreq, input logic mrdy, input logic halt,
                         input logic [5:0] exp);
    vec_t v;
    v.nm = nm; v.rs1 = rs1; v.rs1_en = rs1_en; v.rs2 = rs2; v.rs2_en = rs2_en; v.rd = rd;
    v.ld = ld; v.redir = redir; v.start = start; v.mreq = mreq; v.mrdy = mrdy; v.halt = halt;
    v.exp = exp;
    vq.push_back(v);
  endtask

  // Reference model: pipeline mode 0=run 1=mdu wait 2=mem wait 3=halted
  int          m_mode, m_wd, n_mode, n_wd;
  bit          m_to, n_to;
  logic [31:0] m_stall;
  logic [15:0] m_flush;
  logic [5:0]  e_ctl;
  bit          e_busy, e_halted, e_to;

  task automatic model_eval();
    bit lu;
    bit expire;
    lu = ex_load && ex_rd != 0 &&
         ((id_rs1_en && id_rs1 == ex_rd) || (id_rs2_en && id_rs2 == ex_rd));
    n_mode = m_mode; n_wd = m_wd; n_to = m_to;
    e_ctl = 6'b000000; e_busy = 0; e_halted = 0; expire = 0;
    if (!rst_n) begin
      e_ctl = 6'b000011;
      n_mode = 0; n_wd = 0; n_to = 0;
    end else if (m_mode == 0) begin
      if (mem_req && !mem_ready) n_mode = 2;
      else if (ex_mdu_start) begin n_mode = 1; n_wd = 0; end
      else if (halt_req) n_mode = 3;
      else if (ex_redirect) e_ctl = 6'b111111;
      else if (lu) e_ctl = 6'b001101;
      else e_ctl = 6'b111100;
    end else if (m_mode == 1) begin
      e_busy = 1;
      if (mdu_done) begin e_ctl = 6'b111100; n_mode = 0; end
      else if (m_wd == 255) begin e_ctl = 6'b111100; n_mode = 0; expire = 1; n_to = 1; end
      else n_wd = m_wd + 1;
    end else if (m_mode == 2) begin
      if (mem_ready) begin e_ctl = 6'b111100; n_mode = 0; end
    end else begin
      e_halted = 1;
      if (!halt_req) n_mode = 0;
    end
    e_to = rst_n && (m_to || expire);
  endtask

  task automatic chk_counters(input string nm, input logic [31:0] stall_exp, input logic [15:0] flush_exp);
`ifdef HAZARD_CTRL_PERF_EN
    chk({nm, "_stall"}, stall_cycles, stall_exp);
    chk({nm, "_flush"}, flush_count, flush_exp);
`else
    chk({nm, "_stall"}, stall_cycles, 32'd0);
    chk({nm, "_flush"}, flush_count, 16'd0);
`endif
  endtask

  initial begin
    int pc0_n, busy_n;
    bit rel;

    set_idle();
    rst_n = 1'b0;
    #1;
    chk("init_rst_ctl", ctl, 6'b000011);
    do_reset();
    #1;
    chk_counters("after_rst", 32'd0, 16'd0);
    chk("after_rst_ctl", ctl, 6'b111100);
    chk("after_rst_timeout", mdu_timeout, 1'b0);

    // Single-cycle decisions from RUN; each vector starts from a fresh reset.
    add_vec("idle",          5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 6'b111100);
    add_vec("lu_rs1",        5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0, 0, 0, 6'b001101);
    add_vec("lu_rs2",        5'd3, 1, 5'd7, 1, 5'd7, 1, 0, 0, 0, 0, 0, 6'b001101);
    add_vec("lu_rd0",        5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 0, 0, 0, 0, 6'b111100);
    add_vec("lu_rs1_off",    5'd5, 0, 5'd0, 0, 5'd5, 1, 0, 0, 0, 0, 0, 6'b111100);
    add_vec("no_load",       5'd5, 1, 5'd5, 1, 5'd5, 0, 0, 0, 0, 0, 0, 6'b111100);
    add_vec("redir_lu",      5'd9, 1, 5'd0, 0, 5'd9, 1, 1, 0, 0, 0, 0, 6'b111111);
    add_vec("redir",         5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 0, 0, 6'b111111);
    add_vec("halt_redir",    5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 0, 1, 6'b000000);
    add_vec("start_halt",    5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 0, 0, 1, 6'b000000);
    add_vec("mem_start",     5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 1, 0, 1, 6'b000000);
    add_vec("memrdy_lu",     5'd4, 0, 5'd4, 1, 5'd4, 1, 0, 0, 1, 1, 0, 6'b001101);

    foreach (vq[i]) begin
      do_reset();
      id_rs1 = vq[i].rs1; id_rs1_en = vq[i].rs1_en; id_rs2 = vq[i].rs2; id_rs2_en = vq[i].rs2_en;
      ex_rd = vq[i].rd; ex_load = vq[i].ld; ex_redirect = vq[i].redir; ex_mdu_start = vq[i].start;
      mem_req = vq[i].mreq; mem_ready = vq[i].mrdy; halt_req = vq[i].halt;
      #1;
      chk({"vec_", vq[i].nm}, ctl, vq[i].exp);
    end

    // Load-use gives exactly one bubble
    do_reset();
    ex_load = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_en = 1;
    #1;
    chk("lu_cycle", {pc_en, ifid_en, idex_flush}, 3'b001);
    @(negedge clk);
    set_idle();
    #1;
    chk("lu_after", ctl, 6'b111100);

    // Redirect beats load-use and counts as one flush
    do_reset();
    ex_load = 1; ex_rd = 5'd6; id_rs2 = 5'd6; id_rs2_en = 1; ex_redirect = 1;
    #1;
    chk("redir_lu_seq", {pc_en, ifid_flush, idex_flush}, 3'b111);
    @(negedge clk);
    set_idle();
    #1;
    chk_counters("redir_lu_cnt", 32'd0, 16'd1);

    // MDU op completing four cycles after issue
    do_reset();
    pc0_n = 0; busy_n = 0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      set_idle();
      ex_mdu_start = (c == 0);
      mdu_done = (c == 4);
      #1;
      if (!pc_en) pc0_n++;
      if (mdu_busy) busy_n++;
      if (c == 4) chk("mdu_done_ctl", ctl, 6'b111100);
    end
    chk("mdu_stall_cycles", pc0_n, 4);
    chk("mdu_busy_cycles", busy_n, 4);
    @(negedge clk);
    set_idle();
    #1;
    chk("mdu_back_run", {mdu_busy, ctl}, 7'b0111100);
    chk_counters("mdu_cnt", 32'd4, 16'd0);

    // MDU never completes: watchdog releases and latches the error
    do_reset();
    ex_mdu_start = 1;
    #1;
    chk("wd_start_ctl", ctl, 6'b000000);
    busy_n = 0; rel = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      set_idle();
      #1;
      if (mdu_busy) busy_n++;
      if (pc_en) begin
        rel = 1;
        break;
      end
    end
    chk("wd_released", rel, 1'b1);
    chk("wd_busy_cycles", busy_n, 256);
    chk("wd_timeout_set", mdu_timeout, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("wd_sticky", {mdu_timeout, mdu_busy, ctl}, 8'b10111100);
    end
    chk_counters("wd_cnt", 32'd256, 16'd0);
    do_reset();
    #1;
    chk("wd_cleared", mdu_timeout, 1'b0);

    // Memory stall outranks a simultaneous MDU start
    do_reset();
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      mem_req = 1; mem_ready = 0; ex_mdu_start = 1;
      #1;
      chk("mem_wait_ctl", {mdu_busy, ctl}, 7'b0000000);
    end
    @(negedge clk);
    mem_ready = 1;
    #1;
    chk("mem_release", {mdu_busy, ctl}, 7'b0111100);
    @(negedge clk);
    set_idle();
    #1;
    chk("mem_back_run", {mdu_busy, ctl}, 7'b0111100);
    chk_counters("mem_cnt", 32'd3, 16'd0);
    @(negedge clk);
    mem_req = 1; mem_ready = 0;
    #1;
    chk("mem_wait2", ctl, 6'b000000);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("mem_rst_ctl", ctl, 6'b000011);
    @(negedge clk);
    rst_n = 1;
    set_idle();
    #1;
    chk("mem_rst_run", {mdu_busy, halted, ctl}, 8'b00111100);
    chk_counters("mem_rst_cnt", 32'd0, 16'd0);

    // Halt holds until request drops, with enables low on the exit cycle
    do_reset();
    halt_req = 1;
    #1;
    chk("halt_enter", {halted, ctl}, 7'b0000000);
    @(negedge clk);
    #1;
    chk("halt_hold", {halted, ctl}, 7'b1000000);
    @(negedge clk);
    halt_req = 0;
    #1;
    chk("halt_exit", {halted, ctl}, 7'b1000000);
    @(negedge clk);
    #1;
    chk("halt_run", {halted, ctl}, 7'b0111100);

    // Random traffic against the reference model
    do_reset();
    m_mode = 0; m_wd = 0; m_to = 0; m_stall = 32'd0; m_flush = 16'd0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n        = ($urandom_range(0, 99) != 0);
      id_rs1       = 5'($urandom_range(0, 7));
      id_rs2       = 5'($urandom_range(0, 7));
      ex_rd        = 5'($urandom_range(0, 7));
      id_rs1_en    = 1'($urandom_range(0, 1));
      id_rs2_en    = 1'($urandom_range(0, 1));
      ex_load      = 1'($urandom_range(0, 1));
      ex_redirect  = ($urandom_range(0, 4) == 0);
      ex_mdu_start = ($urandom_range(0, 9) == 0);
      mdu_done     = ($urandom_range(0, 3) == 0);
      mem_req      = ($urandom_range(0, 3) == 0);
      mem_ready    = 1'($urandom_range(0, 1));
      halt_req     = ($urandom_range(0, 9) == 0);
      #1;
      model_eval();
      chk("rnd_ctl", ctl, e_ctl);
      chk("rnd_status", {mdu_busy, halted, mdu_timeout}, {e_busy, e_halted, e_to});
      chk_counters("rnd", m_stall, m_flush);
      @(posedge clk);
      m_mode = n_mode; m_wd = n_wd; m_to = n_to;
      if (!rst_n) begin
        m_stall = 32'd0;
        m_flush = 16'd0;
      end else begin
        if (!e_ctl[5]) m_stall = m_stall + 32'd1;
        if (e_ctl[0]) m_flush = m_flush + 16'd1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  reset, synchronous, active-low.
REQ-002 SHALL have ports: id_rs1, id_rs2  in  5 each  decode-stage source registers; id_rs1_en, id_rs2_en  in  1 each  source-valid flags.
REQ-003 SHALL have ports: ex_rd  in  5  EX-stage destination; ex_load  in  1  EX instruction is a load; ex_redirect  in  1  taken branch/jal/jalr in EX; ex_mdu_start  in  1  multi-cycle mul/div issued in EX.
REQ-004 SHALL have ports: mdu_done  in  1  MDU result valid; mem_req  in  1  MEM-stage data access; mem_ready  in  1  data memory accepts/returns; halt_req  in  1  external halt.
REQ-005 SHALL have ports: pc_en, ifid_en, idex_en, exmem_en  out  1 each  stage-register enables; ifid_flush, idex_flush  out  1 each  insert bubble; mdu_busy, halted  out  1 each; mdu_timeout  out  1  sticky error; stall_cycles  out  32; flush_count  out  16.

Function
REQ-006 SHALL define load_use = ex_load & (ex_rd!=0) & ((id_rs1_en & id_rs1==ex_rd) | (id_rs2_en & id_rs2==ex_rd)).
REQ-007 SHALL implement FSM states RUN, MDU_WAIT, MEM_WAIT, HALT; state register updates on clk rising edge only.
REQ-008 SHALL, in RUN, evaluate with fixed priority: mem_req&!mem_ready > ex_mdu_start > halt_req > ex_redirect > load_use > none.
REQ-009 SHALL, in RUN with mem_req&!mem_ready: all four enables 0, no flush, next state MEM_WAIT.
REQ-010 SHALL, in RUN with ex_mdu_start: all four enables 0, next state MDU_WAIT, watchdog cleared to 0.
REQ-011 SHALL, in RUN with halt_req: all enables 0, next state HALT.
REQ-012 SHALL, in RUN with ex_redirect: all enables 1, ifid_flush=1, idex_flush=1, stay RUN; redirect overrides load_use in the same cycle.
REQ-013 SHALL, in RUN with load_use only: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1, stay RUN (exactly one bubble per hazard).
REQ-014 SHALL, in RUN with no condition: all enables 1, no flush.
REQ-015 SHALL, in MEM_WAIT: all enables 0 while mem_ready=0; on mem_ready=1 all enables 1 in that same cycle, next state RUN.
REQ-016 SHALL, in MDU_WAIT: mdu_busy=1, all enables 0; on mdu_done=1 all enables 1 in that cycle, next state RUN; ex_redirect, load_use, halt_req ignored.
REQ-017 SHALL run an 8-bit watchdog in MDU_WAIT, incrementing each cycle without mdu_done; on reaching 255, set mdu_timeout=1 (sticky until reset), enables 1 that cycle, next state RUN.
REQ-018 SHALL, in HALT: halted=1, all enables 0; on halt_req=0 next state RUN, enables stay 0 in that cycle.
REQ-019 SHALL keep all outputs except counters combinational from state and inputs (zero-cycle response).

Reset
REQ-020 SHALL, while rst_n=0 at a clk edge: state RUN, watchdog 0, mdu_timeout 0, counters 0.
REQ-021 SHALL, while rst_n=0, drive all four enables 0, ifid_flush=1, idex_flush=1, mdu_busy=0, halted=0; reset mid-MDU_WAIT/MEM_WAIT aborts the wait.

Configuration
REQ-022 SHALL, with HAZARD_CTRL_PERF_EN defined, increment stall_cycles each cycle pc_en=0 and rst_n=1, and increment flush_count each cycle idex_flush=1 and rst_n=1; both wrap to 0 on overflow.
REQ-023 SHALL, without HAZARD_CTRL_PERF_EN, tie stall_cycles and flush_count to 0 and instantiate no counter flops.

Verification
REQ-024 SHALL cover: ex_load=1, ex_rd=5, id_rs1=5, id_rs1_en=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 one cycle; ex_rd=0 same stimulus -> no stall.
REQ-025 SHALL cover: load_use and ex_redirect together -> ifid_flush=idex_flush=1, pc_en=1; flush_count +1 (PERF_EN).
REQ-026 SHALL cover: ex_mdu_start, mdu_done after 4 cycles -> enables 0 for 4 cycles, 1 on the done cycle, mdu_busy high 4 cycles, stall_cycles=4.
REQ-027 SHALL cover: ex_mdu_start, mdu_done never -> mdu_timeout=1 after 255 cycles in MDU_WAIT, state RUN, sticky until rst_n=0.
REQ-028 SHALL cover: mem_req=1, mem_ready=0 for 3 cycles with simultaneous ex_mdu_start -> MEM_WAIT taken first, release on mem_ready; rst_n=0 mid-wait -> RUN next cycle, counters 0.
